key_event_queue: RTL
====================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 8; FIFO entries; power of two, 2..64.
REQ-002 Parameter REPEAT_FILTER, default 1; 1 drops typematic repeat presses, 0 queues them.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_valid  input  1  one-cycle strobe from keyboard decoder; key_down and last_change are valid in the same cycle.
REQ-006 last_change  input  9  {extend, scancode[7:0]} of the event.
REQ-007 key_down  input  512  decoder's held-key vector, already updated in the key_valid cycle.
REQ-008 ev_ready  input  1  consumer accepts the head entry.
REQ-009 clr_ovf  input  1  clears the overflow flag.
REQ-010 ev_valid  output  1  queue non-empty; head entry on ev_code/ev_press.
REQ-011 ev_code  output  9  head entry key code.
REQ-012 ev_press  output  1  head entry type: 1 = press, 0 = release.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky: an event was dropped because the queue was full.

Function
REQ-015 Event classification: on key_valid=1, press = key_down[last_change], code = last_change.
REQ-016 Shadow vector rep[511:0] holds keys already reported as pressed.
REQ-017 Accepted event: release always; press only if REPEAT_FILTER=0 or rep[code]=0.
REQ-018 A filtered (repeat) press is discarded silently: no queue write, no overflow.
REQ-019 rep update on key_valid: accepted press sets rep[code]; release clears rep[code].
REQ-020 rep updates even if the queue write is dropped for fullness.
REQ-021 Push: accepted event written to tail on the same rising edge as key_valid; visible at the head next cycle if the queue was empty (1-cycle latency).
REQ-022 Output mode: first-word-fall-through; ev_valid = (count != 0); ev_code and ev_press driven from the head entry and held stable while ev_valid=1 and ev_ready=0.
REQ-023 Pop: occurs on a rising edge with ev_valid=1 and ev_ready=1; ev_ready is ignored when empty.
REQ-024 Simultaneous push and pop, not full: both occur; count unchanged.
REQ-025 Full with push and pop in the same cycle: both occur; no drop; count stays DEPTH.
REQ-026 Full with push and no pop: event dropped; overflow set; contents unchanged.
REQ-027 Empty with push and ev_ready=1: push only; count becomes 1.
REQ-028 Pointer width: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 Occupancy arithmetic: count updates +1 on push, -1 on pop, 0 on both or neither; never exceeds DEPTH and never goes below 0.
REQ-030 Overflow flag: set by drop; cleared by clr_ovf=1; if a drop and clr_ovf occur in the same cycle, set wins.
REQ-031 Control path is pure data-path/FIFO control; no further state machine. Storage is DEPTH x 10 bits.

Reset
REQ-032 On rst=1, immediately and asynchronously: pointers=0, count=0, ev_valid=0, overflow=0, rep=all zeros.
REQ-033 ev_code/ev_press read 0 during reset; thereafter they are don't-care while ev_valid=0.
REQ-034 Reset mid-operation discards all queued entries and shadow state; a key held across reset is reported again on its next make repeat.
REQ-035 Behaviour resumes on the first rising edge after rst deasserts.

Verification
REQ-036 Single key: press 0x01C (A), then release 0x01C, ev_ready=1 -> entries (0x01C,1), (0x01C,0); each appears 1 cycle after its strobe.
REQ-037 Typematic repeat: REPEAT_FILTER=1, 5 press strobes of 0x174 then 1 release -> exactly 2 entries. With REPEAT_FILTER=0 -> 6 entries.
REQ-038 Overflow: DEPTH=8, ev_ready=0, 10 distinct presses -> count=8, overflow=1, head=first code. Then clr_ovf pulse -> overflow=0. Drain -> the 8 codes in order.
REQ-039 Full push+pop: fill to 8; same cycle key_valid=1 and ev_ready=1 -> count stays 8, overflow=0, new code at tail.
REQ-040 Wrap-around: 20 press/release pairs with random ev_ready back-pressure -> order preserved, no loss while count<8, pointers wrap.
REQ-041 Async reset: assert rst between clock edges with count=3 -> count=0, ev_valid=0 before the next edge; a subsequent press of the previously held key is queued.

Source files
------------

// File: rtl/key_event_queue.sv
// key_event_queue
// ---------------
// Captures key press and release events from a keyboard decoder in a small
// first-word-fall-through FIFO. Typematic repeat presses can be filtered out
// with a shadow vector of keys that have already been reported as pressed.
//
// Parameters
//   DEPTH          number of FIFO entries (power of two, 2..64)
//   REPEAT_FILTER  1 = drop repeat presses of a key already reported, 0 = keep
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   key_valid    one-cycle event strobe from the decoder
//   last_change  {extend, scancode} of the event
//   key_down     decoder held-key vector, already updated in the strobe cycle
//   ev_ready     consumer accepts the head entry
//   clr_ovf      clears the sticky overflow flag
//   ev_valid     queue non-empty
//   ev_code      head entry key code
//   ev_press     head entry type (1 = press, 0 = release)
//   count        number of stored entries
//   overflow     sticky: an event was dropped because the queue was full
module key_event_queue #(
    parameter int DEPTH         = 8,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_valid,
    input  logic [8:0]               last_change,
    input  logic [511:0]             key_down,
    input  logic                     ev_ready,
    input  logic                     clr_ovf,
    output logic                     ev_valid,
    output logic [8:0]               ev_code,
    output logic                     ev_press,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Each entry is {code[8:0], press}.
    logic [9:0]    mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          ev_valid_r;
    logic          ovf_r;
    logic [511:0]  rep_r;

    logic          press_s;
    logic          rep_hit_s;
    logic          accept_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    logic [9:0]    head_s;

    // Event classification, repeat filtering and push/pop/drop decisions.
    always_comb begin
        press_s   = key_down[last_change];
        rep_hit_s = rep_r[last_change];
        accept_s  = 1'b0;
        if (key_valid) begin
            if (!press_s) begin
                accept_s = 1'b1;
            end else if (REPEAT_FILTER == 0) begin
                accept_s = 1'b1;
            end else begin
                accept_s = !rep_hit_s;
            end
        end else begin
            accept_s = 1'b0;
        end
        full_s = (count_r == CW'(DEPTH));
        pop_s  = (count_r != {CW{1'b0}}) && ev_ready;
        // A full queue still takes a push when the head leaves in the same cycle.
        push_s = accept_s && (!full_s || pop_s);
        drop_s = accept_s && full_s && !pop_s;
    end

    // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointer, occupancy, valid and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            ev_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r    <= count_next_s;
            ev_valid_r <= (count_next_s != {CW{1'b0}});
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Shadow of reported presses; updated even when the queue write is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_r <= {512{1'b0}};
        end else if (key_valid) begin
            if (press_s && accept_s) begin
                rep_r[last_change] <= 1'b1;
            end else if (!press_s) begin
                rep_r[last_change] <= 1'b0;
            end
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {last_change, press_s};
        end
    end

    // Head of queue is forced to zero whenever the queue is empty or in reset.
    always_comb begin
        head_s = mem_r[rd_ptr_r];
        if (ev_valid_r) begin
            ev_code  = head_s[9:1];
            ev_press = head_s[0];
        end else begin
            ev_code  = 9'd0;
            ev_press = 1'b0;
        end
    end

    assign ev_valid = ev_valid_r;
    assign count    = count_r;
    assign overflow = ovf_r;

endmodule
